divider: RTL



---
 rtl/divider.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/divider.sv
// ----------------------------------------------------------------------------
// divider
//
// Sequential unsigned integer divider using a restoring shift-subtract
// algorithm, one quotient bit per clock. Operands arrive on a valid/ready
// handshake. The result is held on a second valid/ready handshake until
// downstream consumes it. A zero divisor skips the iteration and returns
// quotient = all ones, remainder = dividend, with div_by_zero_o set.
//
// Parameters
//   width_p        operand / quotient / remainder width (>= 2)
//
// Ports
//   clk_i          clock, rising edge
//   reset_n_i      asynchronous active-low reset
//   valid_i        operand pair on dividend_i / divisor_i is valid
//   ready_o        divider is idle and can accept an operand pair
//   dividend_i     unsigned dividend
//   divisor_i      unsigned divisor
//   valid_o        quotient_o / remainder_o / div_by_zero_o are valid
//   ready_i        downstream consumes the result
//   quotient_o     unsigned quotient
//   remainder_o    unsigned remainder
//   div_by_zero_o  result came from a zero divisor
// ----------------------------------------------------------------------------
module divider #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] dividend_i,
    input  logic [width_p-1:0] divisor_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [width_p-1:0] quotient_o,
    output logic [width_p-1:0] remainder_o,
    output logic               div_by_zero_o
);

    localparam int count_w = $clog2(width_p + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;

    // quot_q starts out holding the dividend; each iteration shifts its MSB
    // out into the trial value and shifts a quotient bit in at the LSB, so
    // after width_p iterations it holds the complete quotient.
    logic [width_p-1:0]   quot_q;
    logic [width_p-1:0]   rem_q;
    logic [width_p-1:0]   divisor_q;
    logic [count_w-1:0]   count_q;
    logic                 dbz_q;

    logic [width_p:0]     trial;
    logic [width_p-1:0]   diff;
    logic                 trial_ge;
    logic                 last_iter;

    // Trial value is one bit wider than the operands so the shifted
    // remainder can never overflow. The true difference always fits in
    // width_p bits whenever it is used, because remainder < divisor.
    assign trial     = {rem_q, quot_q[width_p-1]};
    assign trial_ge  = (trial >= {1'b0, divisor_q});
    assign diff      = trial[width_p-1:0] - divisor_q;
    assign last_iter = (count_q == count_w'(1));

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A zero divisor jumps straight to DONE. DONE only
    // returns to IDLE, so a new pair can never be taken on the same edge
    // that the result is consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = (divisor_i == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath. Operands are captured only in IDLE, so anything on the
    // input bus during BUSY or DONE is ignored. Registers are left alone
    // in DONE, which keeps the result stable under backpressure.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        divisor_q <= divisor_i;
                        count_q   <= count_w'(width_p);
                        if (divisor_i == '0) begin
                            quot_q <= '1;
                            rem_q  <= dividend_i;
                            dbz_q  <= 1'b1;
                        end else begin
                            quot_q <= dividend_i;
                            rem_q  <= '0;
                            dbz_q  <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    quot_q  <= {quot_q[width_p-2:0], trial_ge};
                    rem_q   <= trial_ge ? diff : trial[width_p-1:0];
                    count_q <= count_q - count_w'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // ready_o is gated by reset so it reads 0 while reset is held.
    assign ready_o       = (state_q == IDLE) && reset_n_i;
    assign valid_o       = (state_q == DONE);
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule
